mul_share_arbiter: RTL and testbench

- Shares one signed WIDTH x WIDTH combinational multiplier among NUM_REQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready request handshake and receives a one-cycle response strobe.
- Operands are held stable at the multiplier for LATENCY cycles, so the multiplier is a declared multicycle path.
- Sits between the requesting datapath stages and the shared multiplier instance.

---
 rtl/mul_pkg.sv | 9 +
 rtl/mul_share_arbiter_rr_pick.sv | 25 ++
 rtl/mul_share_arbiter.sv | 83 ++++++++
 tb/tb_mul_share_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and sizing for the shared-multiplier arbiter.
package mul_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_LATENCY = 6;
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction
endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// rr_pick: round-robin first-set pick starting at ptr_i, via a double-width mask.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PW-1:0]      idx_o,
    output logic               any_o
);
    logic [NUM_REQ-1:0]   mask;
    logic [2*NUM_REQ-1:0] dbl, iso;
    always_comb begin
        mask = ~((NUM_REQ'(1) << ptr_i) - NUM_REQ'(1));
        // lower half holds requesters at or above ptr, upper half covers the wrap
        dbl = {req_i, req_i & mask};
        iso = dbl & (~dbl + (2*NUM_REQ)'(1));
        grant_o = iso[NUM_REQ-1:0] | iso[2*NUM_REQ-1:NUM_REQ];
        any_o = |req_i;
        idx_o = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant_o[i]) idx_o = PW'(i);
    end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one signed multiplier held stable for LATENCY cycles.
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]      req_a,
    input  logic [NUM_REQ*WIDTH-1:0]      req_b,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [prod_width(WIDTH)-1:0]  resp_c,
    output logic                          busy
);
    localparam int PW  = $clog2(NUM_REQ);
    localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int PRW = prod_width(WIDTH);

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, owner_q, g_idx;
    logic [CW-1:0]           cnt_q;
    logic signed [WIDTH-1:0] op_a_q, op_b_q;
    logic signed [PRW-1:0]   prod, resp_c_q;
    logic [NUM_REQ-1:0]      grant, resp_valid_q, owner_oh;
    logic                    any, hs, done;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (g_idx),
        .any_o   (any)
    );

    // multicycle path: operands stay frozen for the whole BUSY phase
    assign prod     = op_a_q * op_b_q;
    assign hs       = |(req_valid & req_ready);
    assign done     = (state_q == BUSY) && (cnt_q == '0);
    assign owner_oh = NUM_REQ'(1) << owner_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    always_comb
        state_d = (state_q == IDLE) ? (hs ? BUSY : IDLE) : (done ? IDLE : BUSY);

    always_comb begin
        req_ready = (state_q == IDLE && any) ? grant : '0;
        busy      = (state_q == BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            resp_c_q     <= '0;
            resp_valid_q <= '0;
        end else begin
            resp_valid_q <= done ? owner_oh : '0;
            if (hs) begin
                op_a_q  <= req_a[g_idx*WIDTH +: WIDTH];
                op_b_q  <= req_b[g_idx*WIDTH +: WIDTH];
                owner_q <= g_idx;
                cnt_q   <= CW'(LATENCY - 1);
                ptr_q   <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
            end else if (state_q == BUSY && !done) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (done) resp_c_q <= prod;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_c     = resp_c_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed self-checking bench for the shared-multiplier arbiter.
module tb_mul_share_arbiter;
    logic         clk = 0, rst = 1;
    logic [3:0]   req_valid = '0, req_ready, resp_valid;
    logic [127:0] req_a = '0, req_b = '0;
    logic [63:0]  resp_c;
    logic         busy;
    int checks = 0, failures = 0;

    mul_share_arbiter #(.NUM_REQ(4), .WIDTH(32), .LATENCY(6)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_c(resp_c), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, resp_valid, busy} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 0", {req_ready, resp_valid, busy});
        end
        checks++;
        if (resp_c !== 64'd0) begin
            failures++;
            $display("FAIL reset_resp_c: got %h want 0", resp_c);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        req_a[31:0] = 32'd7;
        req_b[31:0] = -32'sd3;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            req_valid = '0;
            req_a[31:0] = 32'd99;
            checks++;
            if ({busy, resp_valid, req_ready} !== 9'b1_0000_0000) begin
                failures++;
                $display("FAIL single_busy T+%0d: got %b want 100000000", k, {busy, resp_valid, req_ready});
            end
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0001 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_resp_valid: got %b/%b want 0001/0", resp_valid, busy);
        end
        checks++;
        if (resp_c !== -64'sd21) begin
            failures++;
            $display("FAIL single_resp_c: got %h want %h", resp_c, -64'sd21);
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0000 || resp_c !== -64'sd21) begin
            failures++;
            $display("FAIL single_hold: got %b/%h want 0000/%h", resp_valid, resp_c, -64'sd21);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(i + 1);
            req_b[i*32 +: 32] = 32'd10;
        end
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            checks++;
            if (req_ready !== 4'(1 << g)) begin
                failures++;
                $display("FAIL rr_grant %0d: got %b want %b", k, req_ready, 4'(1 << g));
            end
            repeat (7) tick();
            checks++;
            if (resp_valid !== 4'(1 << g)) begin
                failures++;
                $display("FAIL rr_resp_valid %0d: got %b want %b", k, resp_valid, 4'(1 << g));
            end
            checks++;
            if (resp_c !== 64'((g + 1) * 10)) begin
                failures++;
                $display("FAIL rr_resp_c %0d: got %0d want %0d", k, resp_c, (g + 1) * 10);
            end
        end
        req_valid = '0;
        repeat (7) tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req_a[64 +: 32] = 32'd3; req_b[64 +: 32] = 32'd4;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_first: got %b want 0100", req_ready);
        end
        tick();
        // requester 1 raises and drops while busy: must leave no trace
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (5) tick();
        checks++;
        if (resp_valid !== 4'b0100 || resp_c !== 64'd12 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL wrap_resp2: got %b/%0d/%b want 0100/12/0000", resp_valid, resp_c, req_ready);
        end
        req_a[0 +: 32] = 32'd2;  req_b[0 +: 32] = 32'd2;
        req_a[64 +: 32] = 32'd5; req_b[64 +: 32] = 32'd5;
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_grant0: got %b want 0001", req_ready);
        end
        repeat (7) tick();
        checks++;
        if (resp_valid !== 4'b0001 || resp_c !== 64'd4 || req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_resp0: got %b/%0d/%b want 0001/4/0100", resp_valid, resp_c, req_ready);
        end
        repeat (7) tick();
        checks++;
        if (resp_valid !== 4'b0100 || resp_c !== 64'd25) begin
            failures++;
            $display("FAIL wrap_resp2b: got %b/%0d want 0100/25", resp_valid, resp_c);
        end
        req_valid = '0;
        repeat (3) tick();
        req_valid = 4'b1100;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_ptr3: got %b want 1000", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (7) tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] seen;
        do_reset();
        req_a[0 +: 32] = 32'd6; req_b[0 +: 32] = 32'd7;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (6) tick();
        checks++;
        if (resp_c !== 64'd42) begin
            failures++;
            $display("FAIL mid_pre: got %0d want 42", resp_c);
        end
        req_a[32 +: 32] = 32'd5; req_b[32 +: 32] = 32'd5;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1;
        #1;
        checks++;
        if ({busy, resp_valid, req_ready} !== 9'b0 || resp_c !== 64'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %b/%h want 0/0", {busy, resp_valid, req_ready}, resp_c);
        end
        tick();
        rst = 0;
        seen = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen = seen | resp_valid;
        end
        checks++;
        if (seen !== 4'b0000) begin
            failures++;
            $display("FAIL mid_no_resp: got %b want 0000", seen);
        end
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_ptr0: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (7) tick();
    endtask

    task automatic test_extremes();
        req_a[96 +: 32] = 32'h8000_0000; req_b[96 +: 32] = 32'h8000_0000;
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        repeat (6) tick();
        checks++;
        if (resp_valid !== 4'b1000 || resp_c !== 64'h4000_0000_0000_0000) begin
            failures++;
            $display("FAIL ext_min_min: got %b/%h want 1000/4000000000000000", resp_valid, resp_c);
        end
        req_a[96 +: 32] = 32'h7FFF_FFFF; req_b[96 +: 32] = 32'hFFFF_FFFF;
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        repeat (6) tick();
        checks++;
        if (resp_valid !== 4'b1000 || resp_c !== 64'hFFFF_FFFF_8000_0001) begin
            failures++;
            $display("FAIL ext_max_neg1: got %b/%h want 1000/ffffffff80000001", resp_valid, resp_c);
        end
    endtask

    task automatic test_back_to_back();
        req_a[0 +: 32] = 32'd2; req_b[0 +: 32] = 32'd3;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (6) tick();
        req_a[32 +: 32] = -32'sd4; req_b[32 +: 32] = 32'd9;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (resp_valid !== 4'b0001 || resp_c !== 64'd6 || req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL b2b_resp0: got %b/%0d/%b want 0001/6/0010", resp_valid, resp_c, req_ready);
        end
        tick();
        req_valid = '0;
        req_a[32 +: 32] = 32'd100; req_b[32 +: 32] = 32'd100;
        checks++;
        if (busy !== 1'b1 || resp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_busy: got %b/%b want 1/0000", busy, resp_valid);
        end
        repeat (6) tick();
        checks++;
        if (resp_valid !== 4'b0010 || resp_c !== -64'sd36) begin
            failures++;
            $display("FAIL b2b_resp1: got %b/%h want 0010/%h", resp_valid, resp_c, -64'sd36);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_extremes();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
